// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and access-size helpers for the data-memory responder.
package dmem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } dmem_state_t;

  // log2 of the access size in bytes: 0 byte, 1 halfword, 2 word
  function automatic logic [1:0] size_decode(input logic [2:0] f3);
    return f3[1:0];
  endfunction

  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    if (is_store)
      return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering between a 4-byte memory window and the core's
// right-justified load/store data.
module dmem_lane_align
  import dmem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] win,
  input  logic [1:0]        lane,
  input  logic [2:0]        funct3,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] load_data,
  output logic [3:0]        byte_mask,
  output logic [DATA_W-1:0] store_data
);

  logic [DATA_W-1:0] shifted;
  logic signed [7:0]  ld_b;
  logic signed [15:0] ld_h;

  assign shifted    = win >> {lane, 3'b000};
  assign store_data = wr_data << {lane, 3'b000};

  always_comb begin
    ld_b      = shifted[7:0];
    ld_h      = shifted[15:0];
    load_data = '0;
    byte_mask = 4'b0000;
    case (size_decode(funct3))
      2'd0: begin
        if (funct3[2]) load_data = DATA_W'(shifted[7:0]);
        else           load_data = DATA_W'(ld_b);
        byte_mask = 4'b0001 << lane;
      end
      2'd1: begin
        if (funct3[2]) load_data = DATA_W'(shifted[15:0]);
        else           load_data = DATA_W'(ld_h);
        byte_mask = 4'b0011 << lane;
      end
      2'd2: begin
        load_data = shifted;
        byte_mask = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle byte-addressed data memory with a valid/ready request and a one-cycle
// response pulse. Define DMEM_MISALIGN_TRAP_EN to reject misaligned accesses.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              wr,
  input  logic              rd,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [2:0]        funct3,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err
);

  dmem_state_t state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  logic        accept, fire;

  logic              wr_p0, rd_p0;
  logic [ADDR_W-1:0] addr_p0;
  logic [DATA_W-1:0] wr_data_p0;
  logic [2:0]        funct3_p0;

  logic [7:0] mem [2**ADDR_W];

  assign req_ready = (state == IDLE);
  assign accept    = req_valid && req_ready;
  assign fire      = (state == BUSY) && (cnt == 4'd0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (req_valid) begin
        state_nxt = BUSY;
        cnt_nxt   = 4'(LATENCY - 1);
      end
      BUSY: if (cnt == 4'd0) state_nxt = IDLE;
            else             cnt_nxt   = cnt - 4'd1;
      default: state_nxt = IDLE;
    endcase
  end

  // p0: request latched at the accept edge, held for the whole BUSY period
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_p0      <= wr;
      rd_p0      <= rd;
      addr_p0    <= addr;
      wr_data_p0 <= wr_data;
      funct3_p0  <= funct3;
    end
  end

  logic [1:0]        size_p0, lane_p0;
  logic              acc_err;
  logic [ADDR_W-3:0] word_idx;
  logic [DATA_W-1:0] window, load_data, store_data;
  logic [3:0]        byte_mask;
  logic              store_en;

  assign size_p0  = size_decode(funct3_p0);
  assign word_idx = addr_p0[ADDR_W-1:2];

  // Halfword and word lanes are forced to natural alignment inside the word
  always_comb begin
    case (size_p0)
      2'd0:    lane_p0 = addr_p0[1:0];
      2'd1:    lane_p0 = {addr_p0[1], 1'b0};
      default: lane_p0 = 2'b00;
    endcase
  end

`ifdef DMEM_MISALIGN_TRAP_EN
  logic misaligned;
  assign misaligned = ((size_p0 == 2'd1) && addr_p0[0]) ||
                      ((size_p0 == 2'd2) && (addr_p0[1:0] != 2'b00));
`endif

  always_comb begin
    acc_err = 1'b0;
    if (wr_p0 && rd_p0)
      acc_err = 1'b1;
    else if ((wr_p0 || rd_p0) && !f3_legal(funct3_p0, wr_p0))
      acc_err = 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
    else if ((wr_p0 || rd_p0) && misaligned)
      acc_err = 1'b1;
`endif
  end

  always_comb begin
    window = '0;
    for (int i = 0; i < 4; i++)
      window[8*i +: 8] = mem[{word_idx, 2'(i)}];
  end

  dmem_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .win        (window),
    .lane       (lane_p0),
    .funct3     (funct3_p0),
    .wr_data    (wr_data_p0),
    .load_data  (load_data),
    .byte_mask  (byte_mask),
    .store_data (store_data)
  );

  // p1: response registers and store commit on the final BUSY edge
  assign store_en = fire && wr_p0 && !rd_p0 && !acc_err && !reset;

  always_ff @(posedge clk) begin
    if (store_en)
      for (int i = 0; i < 4; i++)
        if (byte_mask[i]) mem[{word_idx, 2'(i)}] <= store_data[8*i +: 8];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_valid <= 1'b0;
      rd_data    <= '0;
      err        <= 1'b0;
    end else begin
      resp_valid <= fire;
      if (fire) begin
        err     <= acc_err;
        rd_data <= (rd_p0 && !wr_p0 && !acc_err) ? load_data : '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomized scoreboard bench for dmem_responder against a byte-array reference model.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        wr = 1'b0, rd = 1'b0;
  logic [8:0]  addr = '0;
  logic [31:0] wr_data = '0;
  logic [2:0]  funct3 = '0;
  logic        req_ready, resp_valid, err;
  logic [31:0] rd_data;

  dmem_responder #(.DATA_W(32), .ADDR_W(9), .LATENCY(LAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .wr         (wr),
    .rd         (rd),
    .addr       (addr),
    .wr_data    (wr_data),
    .funct3     (funct3),
    .resp_valid (resp_valid),
    .rd_data    (rd_data),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] model_mem [512];

  typedef struct {
    logic        e;
    logic [31:0] d;
    int          acc;
  } exp_t;
  exp_t sbq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: RV32I access semantics over a flat little-endian byte array
  function automatic void model_access(input logic w, input logic r, input logic [8:0] a,
                                       input logic [31:0] d, input logic [2:0] f3,
                                       output logic e, output logic [31:0] rdv);
    int n, base;
    logic ok;
    logic [31:0] v;
    e = 1'b0;
    rdv = '0;
    if (w && r) begin e = 1'b1; return; end
    if (!w && !r) return;
    ok = w ? (f3 <= 3'd2) : (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!ok) begin e = 1'b1; return; end
    n = 1 << f3[1:0];
    base = int'(a) - (int'(a) % n);
`ifdef DMEM_MISALIGN_TRAP_EN
    if ((int'(a) % n) != 0) begin e = 1'b1; return; end
`endif
    if (w) begin
      for (int i = 0; i < n; i++) model_mem[(base + i) % 512] = d[8*i +: 8];
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) v |= 32'(model_mem[(base + i) % 512]) << (8 * i);
      if (!f3[2] && n < 4 && v[8*n-1]) v |= ~((32'd1 << (8 * n)) - 32'd1);
      rdv = v;
    end
  endfunction

  // Called at a negedge; returns at the negedge after the accept edge with req_valid still high
  task automatic issue(input logic w, input logic r, input logic [8:0] a, input logic [31:0] d,
                       input logic [2:0] f3, input bit track, input bit force_exp,
                       input logic fe, input logic [31:0] fd, output int acc);
    int waitc = 0;
    logic e;
    logic [31:0] rv;
    wr = w; rd = r; addr = a; wr_data = d; funct3 = f3; req_valid = 1'b1;
    while (!req_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: req_ready got 0 expected 1 after %0d cycles", waitc);
      acc = -1;
      return;
    end
    acc = cyc + 1;
    if (track) begin
      model_access(w, r, a, d, f3, e, rv);
      if (force_exp) begin e = fe; rv = fd; end
      sbq.push_back('{e, rv, acc});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  logic prev_rv = 1'b0;
  exp_t x;
  always @(negedge clk) begin
    if (resp_valid) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_resp: resp_valid got 1 expected 0 (t=%0t)", $time);
      end else begin
        x = sbq.pop_front();
        check("resp_err", {31'b0, err}, {31'b0, x.e});
        check("rd_data", rd_data, x.d);
        check("latency", 32'(cyc - x.acc), 32'(LAT));
        check("ready_in_resp", {31'b0, req_ready}, 32'd1);
        check("single_pulse", {31'b0, prev_rv}, 32'd0);
      end
    end
    prev_rv = resp_valid;
  end

  int a0, a1, a2, gap, sel, dc;
  logic w_r, r_r;

  initial begin
    repeat (3) @(negedge clk);
    check("rst_req_ready", {31'b0, req_ready}, 32'd1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    check("rst_rd_data", rd_data, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 128; i++) issue(1, 0, 9'(i * 4), $urandom, 3'b010, 1, 0, 0, 0, dc);
    idle(1);

    issue(1, 0, 9'h010, 32'hDEADBEEF, 3'b010, 1, 1, 1'b0, 32'h0, dc);
    issue(0, 1, 9'h010, 32'h0, 3'b010, 1, 1, 1'b0, 32'hDEADBEEF, dc);
    issue(0, 1, 9'h013, 32'h0, 3'b000, 1, 1, 1'b0, 32'hFFFFFFDE, dc);
    issue(0, 1, 9'h013, 32'h0, 3'b100, 1, 1, 1'b0, 32'h000000DE, dc);
    issue(0, 1, 9'h012, 32'h0, 3'b001, 1, 1, 1'b0, 32'hFFFFDEAD, dc);
    issue(0, 1, 9'h012, 32'h0, 3'b101, 1, 1, 1'b0, 32'h0000DEAD, dc);
    issue(1, 0, 9'h011, 32'h00000055, 3'b000, 1, 1, 1'b0, 32'h0, dc);
    issue(0, 1, 9'h010, 32'h0, 3'b010, 1, 1, 1'b0, 32'hDEAD55EF, dc);
`ifdef DMEM_MISALIGN_TRAP_EN
    issue(0, 1, 9'h011, 32'h0, 3'b010, 1, 1, 1'b1, 32'h0, dc);
`else
    issue(0, 1, 9'h011, 32'h0, 3'b010, 1, 1, 1'b0, 32'hDEAD55EF, dc);
`endif
    issue(0, 0, 9'h010, 32'h0, 3'b010, 1, 1, 1'b0, 32'h0, dc);
    idle(LAT + 2);

    // Store dropped by reset while pending
    issue(1, 0, 9'h020, 32'h12345678, 3'b010, 0, 0, 0, 0, dc);
    req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("busy_rst_ready", {31'b0, req_ready}, 32'd1);
    check("busy_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    reset = 1'b0;
    idle(LAT + 2);
    check("post_rst_ready", {31'b0, req_ready}, 32'd1);
    issue(0, 1, 9'h020, 32'h0, 3'b010, 1, 0, 0, 0, dc);
    idle(LAT + 2);

    // Back-to-back with req_valid held high
    issue(1, 0, 9'h040, 32'hA5A5_1234, 3'b010, 1, 0, 0, 0, a0);
    issue(0, 1, 9'h040, 32'h0, 3'b010, 1, 1, 1'b0, 32'hA5A5_1234, a1);
    issue(1, 1, 9'h044, 32'h0, 3'b010, 1, 1, 1'b1, 32'h0, a2);
    check("throughput_1", 32'(a1 - a0), 32'(LAT + 1));
    check("throughput_2", 32'(a2 - a1), 32'(LAT + 1));
    idle(LAT + 2);

    for (int k = 0; k < 300; k++) begin
      sel = $urandom_range(0, 9);
      w_r = (sel == 0) || (sel >= 2 && sel <= 5);
      r_r = (sel == 0) || (sel >= 6);
      issue(w_r, r_r, 9'($urandom), $urandom, 3'($urandom_range(0, 7)), 1, 0, 0, 0, dc);
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end

    req_valid = 1'b0;
    for (int i = 0; i < 20 && sbq.size() > 0; i++) @(negedge clk);
    if (sbq.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: outstanding got %0d expected 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the pipelined RISC-V core. It terminates the core's load/store port (`wr`, `rd`, `addr`, `wr_data` → `rd_data`) and holds a 512-byte byte-addressed little-endian store. It serves RV32I byte, halfword and word loads and stores, and returns read data after a fixed, parameterised latency over a valid/ready handshake. It sits beside the core, replacing the zero-latency data array, so the pipeline can be exercised against a multi-cycle memory.

## Interface
- `DATA_W`, default 32: data width; only 32 is supported.
- `ADDR_W`, default 9: byte-address width; the store size is 2^ADDR_W bytes.
- `LATENCY`, default 1: cycles from the accept edge to the response; legal range 1..15.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  responder idle and able to accept.
- `wr`  in  1  store request.
- `rd`  in  1  load request.
- `addr`  in  ADDR_W  byte address.
- `wr_data`  in  DATA_W  store data, right-justified.
- `funct3`  in  3  access size and sign, per the RV32I encoding.
- `resp_valid`  out  1  one-cycle response pulse.
- `rd_data`  out  DATA_W  load result, sign- or zero-extended.
- `err`  out  1  the request was rejected; qualified by `resp_valid`.

## Operation
- States are IDLE and BUSY.
- `req_ready` = (state == IDLE).
- A request is accepted on an edge where `req_valid && req_ready`. On acceptance:
  - latch `wr`, `rd`, `addr`, `wr_data`, `funct3`;
  - load the counter with LATENCY-1;
  - go to BUSY.
- In BUSY, the counter decrements each edge. On the edge where the counter is 0:
  - perform the access;
  - register `rd_data` and `err`;
  - set `resp_valid` to 1;
  - return to IDLE.
- `resp_valid` drops after one cycle. `rd_data` and `err` hold until the next response.
- Loads:
  - `000` lb, `001` lh, `010` lw, `100` lbu, `101` lhu.
  - The result is assembled little-endian from `addr` upward.
  - lb/lh sign-extend; lbu/lhu zero-extend.
- Stores:
  - `000` sb, `001` sh, `010` sw.
  - Only the addressed bytes are written.
  - The write commits on the response edge.
- Error cases (`err`=1, `rd_data`=0, memory unchanged):
  - `wr` and `rd` both set;
  - an unsupported `funct3` for the given direction.
- `req_valid` with neither `wr` nor `rd` set: the request is accepted as a no-op and responds with `err`=0, `rd_data`=0.
- Aligned accesses never cross the top of the store. Address arithmetic is modulo 2^ADDR_W.
- Memory contents are not affected by reset.

## Timing
- Acceptance on edge N gives `resp_valid` high in the cycle following edge N+LATENCY.
- `req_ready` is high again in the `resp_valid` cycle. The next acceptance can occur at edge N+LATENCY+1, so throughput is one request per LATENCY+1 cycles.
- Only one request is outstanding at a time, so read-after-write to the same address always returns the new data.
- Reset values:
  - state IDLE, counter 0;
  - `req_ready` 1, `resp_valid` 0, `rd_data` 0, `err` 0.
- No request is accepted while `reset` is high.
- Reset during BUSY:
  - the pending request is dropped;
  - a pending store is not committed;
  - no response is issued.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - misaligned lh/lhu/sh (`addr[0]`≠0) and lw/sw (`addr[1:0]`≠0) respond with `err`=1 and `rd_data`=0;
  - memory is unchanged.
- `DMEM_MISALIGN_TRAP_EN` undefined:
  - low address bits are forced to alignment (bit 0 cleared for halfword, bits 1:0 cleared for word);
  - the access proceeds with `err`=0.

## Structure
- Package `dmem_pkg` holds:
  - the `funct3` load/store encodings as localparams;
  - the state enum `dmem_state_t` (IDLE, BUSY);
  - the size decode helper function.
- Sub-module `dmem_lane_align` is combinational. It:
  - extracts and extends load bytes from the 4-byte window;
  - produces the 4-bit byte-write mask and the lane-shifted store data.
- Storage is a byte array indexed by address. The FSM, counter and request latch live in the top module.

## Test plan
- LATENCY=1:
  - sw `0xDEADBEEF` at `0x010`, then lw at `0x010` → `rd_data`=`0xDEADBEEF`, `err`=0;
  - each `resp_valid` appears exactly one cycle after its accept edge.
- After the above:
  - lb `0x013` → `0xFFFFFFDE`;
  - lbu `0x013` → `0x000000DE`;
  - lh `0x012` → `0xFFFFDEAD`;
  - lhu `0x012` → `0x0000DEAD`.
- sb `0x55` at `0x011`, then lw `0x010` → `0xDEAD55EF`.
- Misaligned lw at `0x011`:
  - with the macro defined → `err`=1, `rd_data`=0;
  - without the macro → the word at `0x010` is returned, `err`=0.
- LATENCY=4:
  - assert reset two cycles after accepting sw `0x12345678` at `0x020`;
  - → no `resp_valid`, a later lw at `0x020` returns the prior contents, and `req_ready`=1 after reset.
- LATENCY=2, `req_valid` held high with three requests → accepts on edges 0, 3, 6; `resp_valid` pulses after edges 2, 5, 8; `wr`=`rd`=1 on the third request → `err`=1.
